// File: rtl/pic_load_ctrl.sv
// ============================================================================
// Module   : pic_load_ctrl
// Brief    : UART byte sequencer into picture RAM with gap-timeout recovery,
//            plus VGA coordinate to RAM address mapping and window gating.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pic_load_ctrl #(
    parameter int PIC_W   = 100,
    parameter int PIC_H   = 100,
    parameter int PIC_X0  = 270,
    parameter int PIC_Y0  = 190,
    parameter int GAP_CYC = 50_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [7:0]  ram_q,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_en,
    output logic [13:0] rd_addr,
    output logic [7:0]  pix_data,
    output logic        loading,
    output logic        frame_done
);

    localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

    localparam logic [GAP_W-1:0] C_GAP_LAST  = GAP_W'(GAP_CYC - 2);
    localparam logic [13:0]      C_LAST_ADDR = 14'(PIC_W * PIC_H - 1);
    localparam logic [13:0]      C_PIC_W     = 14'(PIC_W);
    localparam logic [13:0]      C_X0_14     = 14'(PIC_X0);
    localparam logic [13:0]      C_Y0_14     = 14'(PIC_Y0);
    localparam logic [10:0]      C_X_LO      = 11'(PIC_X0);
    localparam logic [10:0]      C_X_HI      = 11'(PIC_X0 + PIC_W);
    localparam logic [10:0]      C_Y_LO      = 11'(PIC_Y0);
    localparam logic [10:0]      C_Y_HI      = 11'(PIC_Y0 + PIC_H);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [13:0]      cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             wr_en_q, wr_en_d;
    logic [13:0]      wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             frame_done_q, frame_done_d;

    logic             rd_en_q, rd_en_d;
    logic [13:0]      rd_addr_q, rd_addr_d;
    logic             win2_q, win2_d;
    logic [7:0]       pix_data_q, pix_data_d;

    logic             w_last;
    logic             w_in_win;
    logic [13:0]      w_dx, w_dy, w_rd_addr;

    // ------------------------------------------------------------------------
    // Write FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign w_last = (cnt_q == C_LAST_ADDR);

    // ------------------------------------------------------------------------
    // Write FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;

        // A byte is always written at the running counter; it wins over a timeout.
        if (rx_flag) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = rx_data;
        end

        case (state_q)
            ST_IDLE: begin
                gap_d = '0;
                if (rx_flag) begin
                    if (w_last) begin
                        frame_done_d = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d   = cnt_q + 14'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (rx_flag) begin
                    gap_d = '0;
                    if (w_last) begin
                        frame_done_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 14'd1;
                    end
                end else if (gap_q == C_GAP_LAST) begin
                    // gap_q counts idle clocks already elapsed; this is idle clock GAP_CYC-1.
                    gap_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Write FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        loading    = (state_q == ST_LOAD);
        wr_en      = wr_en_q;
        wr_addr    = wr_addr_q;
        wr_data    = wr_data_q;
        frame_done = frame_done_q;
    end

    // ------------------------------------------------------------------------
    // Read path: coordinate -> address -> RAM -> gated pixel
    // ------------------------------------------------------------------------
    assign w_in_win  = ({1'b0, pix_x} >= C_X_LO) && ({1'b0, pix_x} < C_X_HI) &&
                       ({1'b0, pix_y} >= C_Y_LO) && ({1'b0, pix_y} < C_Y_HI);
    assign w_dx      = {4'd0, pix_x} - C_X0_14;
    assign w_dy      = {4'd0, pix_y} - C_Y0_14;
    assign w_rd_addr = w_dy * C_PIC_W + w_dx;

    always_comb begin
        rd_en_d    = w_in_win;
        rd_addr_d  = w_in_win ? w_rd_addr : rd_addr_q;
        win2_d     = rd_en_q;
        pix_data_d = win2_q ? ram_q : 8'h00;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            win2_q     <= 1'b0;
            pix_data_q <= '0;
        end else begin
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            win2_q     <= win2_d;
            pix_data_q <= pix_data_d;
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign pix_data = pix_data_q;

endmodule

`default_nettype wire

// File: doc/pic_load_ctrl.md
# pic_load_ctrl

Controller between the UART receiver, the picture dual-port RAM and the VGA timing generator in the UART-to-VGA picture design. It sequences received bytes into RAM write addresses and recovers from stalled transfers with an inter-byte gap timeout. It also maps the VGA pixel coordinate to a RAM read address and gates the RAM output into a centred picture window over a black background.

## Interface
- PIC_W, 100: picture width in pixels.
- PIC_H, 100: picture height in pixels; PIC_W*PIC_H ≤ 16384.
- PIC_X0, 270: window left column.
- PIC_Y0, 190: window top row.
- GAP_CYC, 50_000: idle clocks after a byte before a partial frame is aborted; ≥ 2.
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- rx_data  in  8  received byte, valid with rx_flag.
- rx_flag  in  1  one-cycle strobe, new byte.
- pix_x  in  10  VGA column being requested.
- pix_y  in  10  VGA row being requested.
- ram_q  in  8  RAM read-port data, 1-cycle latency after rd_en/rd_addr.
- wr_en  out  1  RAM write enable.
- wr_addr  out  14  RAM write address.
- wr_data  out  8  RAM write data.
- rd_en  out  1  RAM read enable.
- rd_addr  out  14  RAM read address.
- pix_data  out  8  pixel colour to VGA (RGB332).
- loading  out  1  high while a frame is partially received.
- frame_done  out  1  one-cycle pulse when the last byte of a frame is written.

## Operation
- Reset: all outputs 0, state IDLE, byte counter 0, gap timer 0.
- Write FSM, two states:
  - IDLE: loading=0. rx_flag → write byte at address 0, go to LOAD.
  - LOAD: loading=1. Each rx_flag → write at the counter value, then increment the counter.
- Last byte (counter = PIC_W*PIC_H-1): the write occurs, frame_done pulses, the counter goes to 0, and the state goes to IDLE.
- Gap timer runs only in LOAD and clears on every rx_flag. When it reaches GAP_CYC-1 with no rx_flag: counter goes to 0, state goes to IDLE, no frame_done. RAM contents are untouched.
- rx_flag in the same cycle as the timeout: the byte wins. It is written at the current counter value and the timer clears.
- Read path:
  - in_win = (PIC_X0 ≤ pix_x < PIC_X0+PIC_W) and (PIC_Y0 ≤ pix_y < PIC_Y0+PIC_H).
  - rd_addr = (pix_y-PIC_Y0)*PIC_W + (pix_x-PIC_X0), computed at 14 bits and registered. rd_addr holds its last value when in_win=0.
  - rd_en = in_win, registered.
- pix_data = ram_q when the in_win delayed 2 cycles is high, else 8'h00; registered.
- Read and write use separate RAM ports; no arbitration. A same-address collision returns old RAM data, which is acceptable.

## Timing
- Write latency: rx_flag/rx_data at cycle N → wr_en=1, wr_addr, wr_data at cycle N+1, for exactly one cycle.
- frame_done is high in the same cycle as the last wr_en.
- loading rises at N+1 after the first byte. It falls at N+1 after the last byte, or one cycle after the timeout cycle.
- Read pipeline: pix_x/pix_y at cycle N → rd_en/rd_addr at N+1 → ram_q at N+2 → pix_data at N+3.
- Total read latency is 3 clocks. The VGA generator issues coordinates 3 clocks ahead of hsync/vsync alignment.
- Coordinate 0x3FF (blanking) is always outside the window: pix_data=0, rd_en=0.
- Asynchronous reset mid-frame clears the partial frame and all pipeline stages immediately.

## Test plan
Bench parameters: PIC_W=4, PIC_H=2, PIC_X0=2, PIC_Y0=1, GAP_CYC=20.
- Eight bytes 8'h10..8'h17, rx_flag 10 cycles apart → wr_addr 0..7 with matching wr_data. frame_done pulses once, with the addr-7 write. loading is 1 from the first write until the last.
- Three bytes, then 25 idle cycles, then byte 8'hAA → loading falls 20 cycles after the 3rd rx_flag. 8'hAA is written at addr 0, and there is no frame_done.
- rx_flag exactly on the timeout cycle (19 cycles after the previous byte) → the byte is written at the next address and loading stays 1.
- After a full frame is loaded, sweep pix_x 0..7 on pix_y=1 and pix_y=2:
  - rd_addr = 0..3 for x=2..5 on y=1, and 4..7 on y=2.
  - pix_data = RAM contents 3 cycles later; 8'h00 elsewhere.
  - pix_y=0 and pix_y=3 → rd_en=0 throughout.
- Assert sys_rst after 5 bytes, release, then send 8 bytes → all outputs are 0 during reset. The writes restart at addr 0 and frame_done pulses on the 8th byte.
